// File: rtl/dsc_pkg.sv
// Shared types and helpers for the stochastic-to-binary capture blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    // Bits needed to hold a count of 0..lanes set bits.
    function automatic int clog2_lanes(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/par_acc_lanes_capture_if.sv
// Handshake/data bundle between a conversion driver and par_acc_lanes_capture.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready on the result; no backpressure on lane_in.
// master: drives en, start, lane_in, done_in, out_ready; sees the result.
// slave : the capture block; drives countval, out_valid, overflow, busy.
interface par_acc_lanes_capture_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 10
);
    logic             en;
    logic             start;
    logic [LANES-1:0] lane_in;
    logic             done_in;
    logic             out_ready;
    logic [WIDTH-1:0] countval;
    logic             out_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output en, start, lane_in, done_in, out_ready,
        input  countval, out_valid, overflow, busy
    );

    modport slave (
        input  en, start, lane_in, done_in, out_ready,
        output countval, out_valid, overflow, busy
    );
endinterface

// File: rtl/lane_popcount.sv
// Counts set bits across LANES inputs with a recursive balanced adder tree.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: lanes_i (LANES bits in), cnt_o (clog2_lanes(LANES) bits out).
module lane_popcount
    import dsc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]              lanes_i,
    output logic [clog2_lanes(LANES)-1:0] cnt_o
);
    localparam int PCW = clog2_lanes(LANES);

    generate
        if (LANES == 1) begin : g_leaf
            assign cnt_o = lanes_i;
        end else begin : g_split
            localparam int LO = LANES / 2;
            localparam int HI = LANES - LO;

            logic [clog2_lanes(LO)-1:0] lo_cnt;
            logic [clog2_lanes(HI)-1:0] hi_cnt;

            lane_popcount #(.LANES(LO)) u_lo (
                .lanes_i (lanes_i[LO-1:0]),
                .cnt_o   (lo_cnt)
            );
            lane_popcount #(.LANES(HI)) u_hi (
                .lanes_i (lanes_i[LANES-1:LO]),
                .cnt_o   (hi_cnt)
            );

            assign cnt_o = PCW'(lo_cnt) + PCW'(hi_cnt);
        end
    endgenerate
endmodule

// File: rtl/par_acc_lanes_capture.sv
// Popcounts LANES product bit-streams per cycle into a WIDTH-bit accumulator, freezes on done_in.
// Latency: done_in sampled at edge M -> out_valid/final countval after edge M.
// Backpressure: result held in HOLD until out_ready; start without out_ready is ignored.
// Ports: clk, rst (async, active-low), bus (par_acc_lanes_capture_if.slave).
// Build option PAR_ACC_SAT_EN: saturate at 2**WIDTH-1 instead of wrapping.
// Assumes WIDTH+1 >= clog2_lanes(LANES) so a single cycle's count fits the adder.
module par_acc_lanes_capture
    import dsc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    par_acc_lanes_capture_if.slave   bus
);
    localparam int PCW = clog2_lanes(LANES);

    acc_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             clr;
    logic [PCW-1:0]   pc;
    logic [WIDTH:0]   sum;

    lane_popcount #(.LANES(LANES)) u_popcount (
        .lanes_i (bus.lane_in),
        .cnt_o   (pc)
    );

    // Extra top bit is the carry that flags overflow.
    assign sum = {1'b0, acc_q} + (WIDTH+1)'(pc);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; clr marks every transition that opens a fresh conversion.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    clr     = 1'b1;
                end
            end
            ACC: begin
                // start wins over a simultaneous done_in.
                if (bus.start) begin
                    clr = 1'b1;
                end else if (bus.done_in) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // The result only leaves HOLD once accepted, so it is never dropped.
                if (bus.out_ready) begin
                    state_d = bus.start ? ACC : IDLE;
                    clr     = bus.start;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.busy      = (state_q == ACC);
        bus.countval  = acc_q;
        bus.overflow  = ovf_q;
    end

    // Accumulator datapath; the done cycle's lanes are still added.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == ACC && bus.en) begin
`ifdef PAR_ACC_SAT_EN
            // Once clamped, any further non-zero add carries again and stays clamped.
            if (sum[WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[WIDTH-1:0];
            end
`else
            acc_d = sum[WIDTH-1:0];
            ovf_d = ovf_q | sum[WIDTH];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: doc/par_acc_lanes_capture.md
# par_acc_lanes_capture

Downstream stochastic-to-binary stage for the ordered bit-stream multipliers. Each cycle it counts the 1s across LANES parallel product bit-streams and adds that count to a WIDTH-bit accumulator. When the upstream multiplier raises its done flag, the block freezes the final binary result and presents it through a valid/ready handshake. It replaces free-running lane accumulators, so sweep harnesses can run back-to-back conversions with a clean result boundary.

## Interface
Parameters:
- LANES, 4: number of parallel bit-stream lanes (2**NUM_INPUTS of the upstream multiplier); legal range 2..32.
- WIDTH, 10: accumulator/result width in bits.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  accumulate enable; lanes ignored while low.
- start  input  1  clear accumulator and begin a conversion.
- lane_in  input  LANES  product bit-streams, one bit per lane per cycle.
- done_in  input  1  upstream end-of-conversion flag.
- out_ready  input  1  consumer accepts result.
- countval  output  WIDTH  accumulated result.
- out_valid  output  1  countval holds a final result.
- overflow  output  1  sticky: the sum exceeded 2**WIDTH-1 this conversion.
- busy  output  1  conversion in progress (state ACC).

## Operation
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - start=1 -> ACC; accumulator and overflow cleared.
  - done_in, en and lane_in are ignored.
- ACC:
  - Each cycle with en=1, accumulator += popcount(lane_in).
  - Popcount width is $clog2(LANES+1), zero-extended to WIDTH+1 before the add.
  - done_in=1 -> HOLD. The lane_in of that same cycle is included, if en=1.
  - start=1 in ACC restarts: accumulator and overflow cleared, state stays ACC. start beats a simultaneous done_in.
- HOLD:
  - out_valid=1; countval and overflow frozen.
  - out_ready=1 -> IDLE.
  - start=1 together with out_ready=1 -> ACC, cleared. This gives a back-to-back conversion.
  - start without out_ready is ignored. The result is never dropped.
- Overflow: overflow is set when the (WIDTH+1)-bit sum has its carry bit set. The rest of the behaviour is set by the PAR_ACC_SAT_EN macro.
- en=0 in ACC: the accumulator holds, and done_in is still honoured.

## Timing
- Reset values: countval=0, out_valid=0, overflow=0, busy=0, state IDLE.
- Reset mid-conversion: the result is discarded immediately and asynchronously.
- Conversion timing:
  - start at edge N -> busy=1 after edge N.
  - Lane bits are accumulated from cycle N+1 onward.
  - done_in sampled at edge M -> out_valid=1 and final countval visible after edge M, i.e. one cycle of latency.
- countval updates every ACC cycle, with no combinational path from lane_in to countval.
- out_valid/countval are held stable until out_ready is sampled high.

## Configuration
- PAR_ACC_SAT_EN defined:
  - On overflow the accumulator clamps to 2**WIDTH-1 and stays there for the rest of the conversion.
  - overflow goes high on the first saturating add.
- PAR_ACC_SAT_EN undefined:
  - The accumulator wraps modulo 2**WIDTH.
  - overflow is still set sticky on any carry-out and cleared only by start or reset.

## Structure
- Shared package dsc_pkg:
  - acc_state_t enum (IDLE, ACC, HOLD).
  - popcount width function clog2_lanes(LANES).
- One sub-module, lane_popcount #(LANES):
  - A purely combinational adder tree.
  - Also reused by the wider par_acc variants.

## Test plan
- LANES=4, WIDTH=10. start; lane_in=4'b1011 for 8 cycles with en=1; done_in on the 8th cycle -> out_valid next cycle, countval=24, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles and pulse start meanwhile -> countval stays 24 and out_valid stays 1, the start is ignored. out_ready=1 with start=1 -> busy next cycle, countval cleared to 0.
- WIDTH=4, lane_in=4'b1111 for 5 cycles:
  - with PAR_ACC_SAT_EN -> countval=15, overflow=1;
  - without -> countval=4 (20 mod 16), overflow=1.
- en toggling: lane_in=4'b0001 for 6 cycles with en high on alternate cycles, done on the 6th (en=1) -> countval=3.
- start and done_in both high in ACC after 3 cycles of 4'b1111 -> stays ACC, countval=0, no out_valid.
- rst asserted low mid-ACC with countval=12 -> all outputs 0 immediately; after release, done_in alone gives no out_valid.
